systolic_job_sched: RTL and testbench

- Job-level scheduler for the N1 x N2 systolic MAC array computing one M x M by M x M product.
- On a start command it walks every (row-block, col-block) tile pair and streams M operand slices per tile into the array. It generates the operand-buffer read addresses and a per-tile init strobe.
- It counts result beats returning on the array's valid_D lanes, then reports done, or a timeout/overflow error.
- It sits between the host command interface and the array plus its A/B operand buffers.

---
 rtl/systolic_job_sched.sv | 211 +++++++++++++++++++++
 tb/tb_systolic_job_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_job_sched.sv
// Job-level scheduler for an N1 x N2 systolic MAC array computing one M x M
// by M x M product. Walks every (row-block, col-block) tile pair, streams M
// operand slices per tile, counts returning result beats and reports done,
// timeout or overflow. Every output is a flop.
module systolic_job_sched #(
    parameter int N1       = 4,
    parameter int N2       = 4,
    parameter int M        = 8,
    parameter int DRAIN_TO = 64,
    localparam int AW_A    = $clog2(M * M / N1),
    localparam int AW_B    = $clog2(M * M / N2),
    localparam int RB      = M / N1,
    localparam int CB      = M / N2,
    localparam int RW      = (RB > 1) ? $clog2(RB) : 1,
    localparam int CW      = (CB > 1) ? $clog2(CB) : 1,
    localparam int RCW     = $clog2(M * M + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            feed_stall,
    input  logic [N1-1:0]   valid_D,
    output logic            busy,
    output logic            done,
    output logic            err_timeout,
    output logic            err_overflow,
    output logic            feed_en,
    output logic            tile_init,
    output logic [AW_A-1:0] rd_addr_A,
    output logic [AW_B-1:0] rd_addr_B,
    output logic [RW-1:0]   tile_r,
    output logic [CW-1:0]   tile_c,
    output logic [RCW-1:0]  res_cnt
);

    localparam int KW = (M > 1) ? $clog2(M) : 1;
    localparam int MM = M * M;
    localparam int DW = $clog2(DRAIN_TO + 1);
    localparam int PW = $clog2(N1 + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [RW-1:0]   r_q, r_d;
    logic [CW-1:0]   c_q, c_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [RCW-1:0]  res_cnt_q, res_cnt_d;
    logic            err_timeout_q, err_timeout_d;
    logic            err_overflow_q, err_overflow_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            feed_en_q, feed_en_d;
    logic            tile_init_q, tile_init_d;
    logic [AW_A-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [AW_B-1:0] rd_addr_b_q, rd_addr_b_d;

    logic [PW-1:0]   beats;
    logic [RCW:0]    sum;
    logic            last_beat;

    // Number of rows presenting a valid result this cycle.
    always_comb begin
        beats = '0;
        for (int i = 0; i < N1; i++) begin
            beats = beats + PW'(valid_D[i]);
        end
    end

    // Next-state, tile walk, result counting and registered-output values.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d        = state_q;
        k_d            = k_q;
        r_d            = r_q;
        c_d            = c_q;
        drain_d        = drain_q;
        res_cnt_d      = res_cnt_q;
        err_timeout_d  = err_timeout_q;
        err_overflow_d = err_overflow_q;
        feed_en_d      = 1'b0;
        sum            = {1'b0, res_cnt_q} + (RCW + 1)'(beats);

        // The beat currently on the address outputs is the final one of the job.
        last_beat = (k_q == KW'(M - 1)) && (c_q == CW'(CB - 1)) && (r_q == RW'(RB - 1));

        // Result beats only count while the job is in flight; saturate at M*M.
        if (state_q == S_FEED || state_q == S_DRAIN) begin
            if (sum > (RCW + 1)'(MM)) begin
                res_cnt_d      = RCW'(MM);
                err_overflow_d = 1'b1;
            end else begin
                res_cnt_d = sum[RCW-1:0];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_FEED;
                    k_d            = '0;
                    r_d            = '0;
                    c_d            = '0;
                    res_cnt_d      = '0;
                    err_timeout_d  = 1'b0;
                    err_overflow_d = 1'b0;
                    feed_en_d      = 1'b1;
                end
            end
            S_FEED: begin
                if (last_beat) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else if (!feed_stall) begin
                    feed_en_d = 1'b1;
                    // k is the innermost loop, then c, then r.
                    if (k_q == KW'(M - 1)) begin
                        k_d = '0;
                        if (c_q == CW'(CB - 1)) begin
                            c_d = '0;
                            r_d = r_q + RW'(1);
                        end else begin
                            c_d = c_q + CW'(1);
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (res_cnt_d == RCW'(MM)) begin
                    state_d = S_DONE;
                end else if (drain_q == DW'(DRAIN_TO - 1)) begin
                    state_d       = S_DONE;
                    err_timeout_d = 1'b1;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d == S_FEED) || (state_d == S_DRAIN);
        done_d      = (state_d == S_DONE);
        tile_init_d = feed_en_d && (k_d == KW'(M - 1));
        // Addresses follow the held k/r/c, so they freeze whenever feeding stops.
        rd_addr_a_d = AW_A'(int'(r_d) * M + int'(k_d));
        rd_addr_b_d = AW_B'(int'(c_d) * M + int'(k_d));
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values from
        // before this edge, regardless of statement order.
        if (rst) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            r_q            <= '0;
            c_q            <= '0;
            drain_q        <= '0;
            res_cnt_q      <= '0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            feed_en_q      <= 1'b0;
            tile_init_q    <= 1'b0;
            rd_addr_a_q    <= '0;
            rd_addr_b_q    <= '0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            r_q            <= r_d;
            c_q            <= c_d;
            drain_q        <= drain_d;
            res_cnt_q      <= res_cnt_d;
            err_timeout_q  <= err_timeout_d;
            err_overflow_q <= err_overflow_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            feed_en_q      <= feed_en_d;
            tile_init_q    <= tile_init_d;
            rd_addr_a_q    <= rd_addr_a_d;
            rd_addr_b_q    <= rd_addr_b_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err_timeout  = err_timeout_q;
    assign err_overflow = err_overflow_q;
    assign feed_en      = feed_en_q;
    assign tile_init    = tile_init_q;
    assign rd_addr_A    = rd_addr_a_q;
    assign rd_addr_B    = rd_addr_b_q;
    assign tile_r       = r_q;
    assign tile_c       = c_q;
    assign res_cnt      = res_cnt_q;

endmodule

// File: tb/tb_systolic_job_sched.sv
// Directed bench for systolic_job_sched with M=8, N1=N2=4, DRAIN_TO=10.
// Cycle 0 is the cycle in which start is driven; outputs are sampled 1 time
// unit after each rising edge and labelled with the cycle they belong to.
module tb_systolic_job_sched;

    localparam int N1       = 4;
    localparam int N2       = 4;
    localparam int M        = 8;
    localparam int DRAIN_TO = 10;

    logic       clk;
    logic       rst;
    logic       start;
    logic       feed_stall;
    logic [3:0] valid_D;
    logic       busy;
    logic       done;
    logic       err_timeout;
    logic       err_overflow;
    logic       feed_en;
    logic       tile_init;
    logic [3:0] rd_addr_A;
    logic [3:0] rd_addr_B;
    logic [0:0] tile_r;
    logic [0:0] tile_c;
    logic [6:0] res_cnt;

    systolic_job_sched #(
        .N1       (N1),
        .N2       (N2),
        .M        (M),
        .DRAIN_TO (DRAIN_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .feed_stall   (feed_stall),
        .valid_D      (valid_D),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow),
        .feed_en      (feed_en),
        .tile_init    (tile_init),
        .rd_addr_A    (rd_addr_A),
        .rd_addr_B    (rd_addr_B),
        .tile_r       (tile_r),
        .tile_c       (tile_c),
        .res_cnt      (res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic fe;
        logic ti;
        int   a;
        int   b;
        int   tr;
        int   tc;
        logic bsy;
        logic dn;
        int   res;
    } vec_t;

    vec_t vec [15];

    int checks   = 0;
    int failures = 0;

    // Stimulus schedule, expressed in cycles relative to the start cycle.
    int         cyc;
    int         start_at, start_at2, start_at3, rst_at;
    int         vd_lo, vd_hi, st_lo, st_hi;
    logic [3:0] vd_val;
    int         fe_cnt, done_cnt;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        start      = (cyc == start_at) || (cyc == start_at2) || (cyc == start_at3);
        rst        = (cyc == rst_at);
        feed_stall = (cyc >= st_lo) && (cyc <= st_hi);
        valid_D    = (cyc >= vd_lo && cyc <= vd_hi) ? vd_val : 4'h0;
        @(posedge clk);
        #1;
        cyc++;
        fe_cnt   += int'(feed_en);
        done_cnt += int'(done);
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic clear_sched();
        cyc       = 0;
        start_at  = -1;
        start_at2 = -1;
        start_at3 = -1;
        rst_at    = -1;
        vd_lo     = -1;
        vd_hi     = -2;
        st_lo     = -1;
        st_hi     = -2;
        vd_val    = 4'hF;
        fe_cnt    = 0;
        done_cnt  = 0;
    endtask

    task automatic new_job();
        clear_sched();
        start_at = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},         busy,         0);
        check({tag, " done"},         done,         0);
        check({tag, " err_timeout"},  err_timeout,  0);
        check({tag, " err_overflow"}, err_overflow, 0);
        check({tag, " feed_en"},      feed_en,      0);
        check({tag, " tile_init"},    tile_init,    0);
        check({tag, " rd_addr_A"},    rd_addr_A,    0);
        check({tag, " rd_addr_B"},    rd_addr_B,    0);
        check({tag, " tile_r"},       tile_r,       0);
        check({tag, " tile_c"},       tile_c,       0);
        check({tag, " res_cnt"},      res_cnt,      0);
    endtask

    // Unstalled job: extra starts at cycle 10 (busy) and 36 (DONE) must be
    // ignored; 64 beats arrive as 4'hF over cycles 20..35.
    task automatic run_nominal(input string tag);
        new_job();
        start_at2 = 10;
        start_at3 = 36;
        vd_lo     = 20;
        vd_hi     = 35;
        for (int i = 0; i < 15; i++) begin
            step_to(vec[i].cyc);
            check($sformatf("%s c%0d feed_en", tag, cyc),   feed_en,   int'(vec[i].fe));
            check($sformatf("%s c%0d tile_init", tag, cyc), tile_init, int'(vec[i].ti));
            check($sformatf("%s c%0d rd_addr_A", tag, cyc), rd_addr_A, vec[i].a);
            check($sformatf("%s c%0d rd_addr_B", tag, cyc), rd_addr_B, vec[i].b);
            check($sformatf("%s c%0d tile_r", tag, cyc),    tile_r,    vec[i].tr);
            check($sformatf("%s c%0d tile_c", tag, cyc),    tile_c,    vec[i].tc);
            check($sformatf("%s c%0d busy", tag, cyc),      busy,      int'(vec[i].bsy));
            check($sformatf("%s c%0d done", tag, cyc),      done,      int'(vec[i].dn));
            check($sformatf("%s c%0d res_cnt", tag, cyc),   res_cnt,   vec[i].res);
        end
        check({tag, " feed cycles"},  fe_cnt,       32);
        check({tag, " done pulses"},  done_cnt,     1);
        check({tag, " err_timeout"},  err_timeout,  0);
        check({tag, " err_overflow"}, err_overflow, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        //            cyc fe ti  A   B  r  c busy done res
        vec[0]  = '{ 1, 1, 0,  0,  0, 0, 0, 1, 0,  0};
        vec[1]  = '{ 8, 1, 1,  7,  7, 0, 0, 1, 0,  0};
        vec[2]  = '{ 9, 1, 0,  0,  8, 0, 1, 1, 0,  0};
        vec[3]  = '{11, 1, 0,  2, 10, 0, 1, 1, 0,  0};
        vec[4]  = '{16, 1, 1,  7, 15, 0, 1, 1, 0,  0};
        vec[5]  = '{17, 1, 0,  8,  0, 1, 0, 1, 0,  0};
        vec[6]  = '{20, 1, 0, 11,  3, 1, 0, 1, 0,  0};
        vec[7]  = '{24, 1, 1, 15,  7, 1, 0, 1, 0, 16};
        vec[8]  = '{25, 1, 0,  8,  8, 1, 1, 1, 0, 20};
        vec[9]  = '{32, 1, 1, 15, 15, 1, 1, 1, 0, 48};
        vec[10] = '{33, 0, 0, 15, 15, 1, 1, 1, 0, 52};
        vec[11] = '{35, 0, 0, 15, 15, 1, 1, 1, 0, 60};
        vec[12] = '{36, 0, 0, 15, 15, 1, 1, 0, 1, 64};
        vec[13] = '{37, 0, 0, 15, 15, 1, 1, 0, 0, 64};
        vec[14] = '{38, 0, 0, 15, 15, 1, 1, 0, 0, 64};

        clear_sched();
        rst        = 1'b1;
        start      = 1'b0;
        feed_stall = 1'b0;
        valid_D    = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        // valid_D in IDLE must not count.
        clear_sched();
        vd_lo = 0;
        vd_hi = 3;
        step_to(5);
        check("idle res_cnt", res_cnt, 0);
        check("idle busy",    busy,    0);
        check("idle done",    done_cnt, 0);

        run_nominal("nom");

        // Three stall cycles mid-tile shift the job end by 3.
        new_job();
        st_lo = 10;
        st_hi = 12;
        vd_lo = 23;
        vd_hi = 38;
        step_to(10);
        check("stall c10 feed_en",   feed_en,   1);
        check("stall c10 rd_addr_A", rd_addr_A, 1);
        check("stall c10 rd_addr_B", rd_addr_B, 9);
        step_to(13);
        check("stall c13 feed_en",   feed_en,   0);
        check("stall c13 rd_addr_A", rd_addr_A, 1);
        check("stall c13 rd_addr_B", rd_addr_B, 9);
        check("stall c13 fe so far", fe_cnt,    10);
        step_to(14);
        check("stall c14 feed_en",   feed_en,   1);
        check("stall c14 rd_addr_B", rd_addr_B, 10);
        step_to(35);
        check("stall c35 tile_init", tile_init, 1);
        check("stall c35 rd_addr_A", rd_addr_A, 15);
        step_to(36);
        check("stall c36 feed_en",   feed_en,   0);
        check("stall c36 busy",      busy,      1);
        check("stall c36 res_cnt",   res_cnt,   52);
        step_to(38);
        check("stall c38 done",      done,      0);
        step_to(39);
        check("stall c39 done",      done,      1);
        check("stall c39 res_cnt",   res_cnt,   64);
        step_to(40);
        check("stall feed cycles",   fe_cnt,    32);
        check("stall done pulses",   done_cnt,  1);

        // Only 60 beats: DRAIN entered at 33 times out 10 cycles later.
        new_job();
        vd_lo = 20;
        vd_hi = 34;
        step_to(33);
        check("tmo c33 busy",        busy,        1);
        check("tmo c33 feed_en",     feed_en,     0);
        check("tmo c33 res_cnt",     res_cnt,     52);
        step_to(42);
        check("tmo c42 done",        done,        0);
        check("tmo c42 err_timeout", err_timeout, 0);
        check("tmo c42 res_cnt",     res_cnt,     60);
        step_to(43);
        check("tmo c43 done",        done,        1);
        check("tmo c43 busy",        busy,        0);
        check("tmo c43 err_timeout", err_timeout, 1);
        check("tmo c43 res_cnt",     res_cnt,     60);
        step_to(44);
        check("tmo c44 done",        done,        0);
        check("tmo c44 err_timeout", err_timeout, 1);
        check("tmo c44 res_cnt",     res_cnt,     60);

        // 68 beats during FEED: saturate at 64, flag overflow, exit DRAIN at once.
        new_job();
        vd_lo = 5;
        vd_hi = 21;
        step_to(1);
        check("ovf c1 err_timeout",  err_timeout,  0);
        check("ovf c1 res_cnt",      res_cnt,      0);
        step_to(21);
        check("ovf c21 res_cnt",     res_cnt,      64);
        check("ovf c21 err_overflow", err_overflow, 0);
        step_to(22);
        check("ovf c22 res_cnt",     res_cnt,      64);
        check("ovf c22 err_overflow", err_overflow, 1);
        check("ovf c22 feed_en",     feed_en,      1);
        step_to(33);
        check("ovf c33 busy",        busy,         1);
        step_to(34);
        check("ovf c34 done",        done,         1);
        check("ovf c34 err_overflow", err_overflow, 1);
        step_to(36);
        check("ovf c36 err_overflow", err_overflow, 1);
        check("ovf c36 res_cnt",     res_cnt,      64);

        // New start clears the errors and the count.
        new_job();
        step_to(1);
        check("clr c1 err_overflow", err_overflow, 0);
        check("clr c1 err_timeout",  err_timeout,  0);
        check("clr c1 res_cnt",      res_cnt,      0);
        check("clr c1 busy",         busy,         1);
        step_to(45);
        check("clr done pulses",     done_cnt,     1);
        check("clr err_timeout",     err_timeout,  1);

        // Reset during cycle 15 of FEED aborts the job without done.
        new_job();
        vd_lo  = 5;
        vd_hi  = 14;
        rst_at = 15;
        step_to(15);
        check("rst c15 res_cnt",   res_cnt,   40);
        check("rst c15 rd_addr_B", rd_addr_B, 14);
        step_to(16);
        check_all_zero("rst c16");
        step_to(25);
        check("rst no done",       done_cnt,  0);
        check("rst stays idle",    busy,      0);

        run_nominal("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
